// File: rtl/fp_result_serializer.sv
// Purpose: parallel-to-serial output stage; captures one result word and shifts it out one bit per accepted transfer.
// Latency: first bit valid the cycle after load; done_out pulses one cycle after the last bit; idle again the cycle after that.
// Backpressure: rd_in=0 in SHIFT freezes register, count and serial_out for any number of cycles; loads only accepted while idle.
module fp_result_serializer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       ld_in,
    input  logic [WIDTH-1:0]           parallel_in,
    input  logic                       rd_in,
    output logic                       serial_out,
    output logic                       out_valid,
    output logic                       output_rdy,
    output logic                       done_out,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_output_rdy;
    logic               r_done;

    logic [WIDTH-1:0]   w_sreg_shifted;
    logic               w_out_bit;

    // Shift direction is fixed at elaboration: the output end is bit 0 for LSB-first, bit WIDTH-1 otherwise.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign w_out_bit      = r_sreg[0];
        end else begin : g_msb
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign w_out_bit      = r_sreg[WIDTH-1];
        end
    endgenerate

    // FSM: state, shift register, bit count and the flag outputs all update together so outputs come straight from flops.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_output_rdy <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Register holds its last contents while idle; only an accepted load replaces it.
                    if (ld_in) begin
                        r_sreg       <= parallel_in;
                        r_cnt        <= '0;
                        r_state      <= S_SHIFT;
                        r_out_valid  <= 1'b1;
                        r_output_rdy <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // A transfer needs out_valid (implied by this state) and rd_in; otherwise everything holds.
                    if (rd_in) begin
                        r_sreg <= w_sreg_shifted;
                        r_cnt  <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST_IDX) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Single-cycle completion marker; count reads WIDTH here and clears on the way back to idle.
                    r_state      <= S_IDLE;
                    r_done       <= 1'b0;
                    r_output_rdy <= 1'b1;
                    r_cnt        <= '0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_out_valid  <= 1'b0;
                    r_output_rdy <= 1'b1;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    // Serial data is masked to 0 whenever no valid bit is being presented.
    assign serial_out  = r_out_valid & w_out_bit;
    assign out_valid   = r_out_valid;
    assign output_rdy  = r_output_rdy;
    assign done_out    = r_done;
    assign bit_cnt_out = r_cnt;

endmodule

// File: tb/tb_fp_result_serializer.sv
module tb_fp_result_serializer;

    logic        clk;
    logic        rst;

    logic        a_ld, a_rd;
    logic [31:0] a_par;
    logic        a_ser, a_vld, a_rdy, a_done;
    logic [5:0]  a_cnt;

    logic        b_ld, b_rd;
    logic [31:0] b_par;
    logic        b_ser, b_vld, b_rdy, b_done;
    logic [5:0]  b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fp_result_serializer #(.WIDTH(32), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk_in      (clk),
        .rst_in      (rst),
        .ld_in       (a_ld),
        .parallel_in (a_par),
        .rd_in       (a_rd),
        .serial_out  (a_ser),
        .out_valid   (a_vld),
        .output_rdy  (a_rdy),
        .done_out    (a_done),
        .bit_cnt_out (a_cnt)
    );

    fp_result_serializer #(.WIDTH(32), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk_in      (clk),
        .rst_in      (rst),
        .ld_in       (b_ld),
        .parallel_in (b_par),
        .rd_in       (b_rd),
        .serial_out  (b_ser),
        .out_valid   (b_vld),
        .output_rdy  (b_rdy),
        .done_out    (b_done),
        .bit_cnt_out (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word through the LSB-first instance starting from an idle cycle.
    // Stalls rd for stall_n cycles while bit stall_bit is presented (stall_bit<0: no stall).
    // With hold_ld, ld stays high and parallel_in switches to w_next after the first load.
    // The bench-side loader reassembles the word LSB-first and is compared at the end.
    task automatic send(input logic [31:0] w, input int stall_bit, input int stall_n,
                        input bit hold_ld, input logic [31:0] w_next);
        logic [31:0] loader;
        loader = '0;
        a_par = w;
        a_ld  = 1'b1;
        a_rd  = 1'b1;
        step();
        if (hold_ld) a_par = w_next;
        else         a_ld  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("bit", {31'd0, a_ser}, {31'd0, w[i]});
            chk("cnt", {26'd0, a_cnt}, i);
            if (i == 0 || i == 31) begin
                chk("vld_in_shift", {31'd0, a_vld}, 32'd1);
                chk("rdy_in_shift", {31'd0, a_rdy}, 32'd0);
                chk("no_early_done", {31'd0, a_done}, 32'd0);
            end
            if (i == stall_bit) begin
                a_rd = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    chk("stall_bit", {31'd0, a_ser}, {31'd0, w[i]});
                    chk("stall_cnt", {26'd0, a_cnt}, i);
                    chk("stall_no_done", {31'd0, a_done}, 32'd0);
                end
                a_rd = 1'b1;
            end
            loader = {a_ser, loader[31:1]};
            step();
        end
        chk("done_pulse", {31'd0, a_done}, 32'd1);
        chk("done_cnt", {26'd0, a_cnt}, 32'd32);
        chk("done_vld", {31'd0, a_vld}, 32'd0);
        chk("done_rdy", {31'd0, a_rdy}, 32'd0);
        chk("done_ser", {31'd0, a_ser}, 32'd0);
        step();
        chk("idle_rdy", {31'd0, a_rdy}, 32'd1);
        chk("idle_done", {31'd0, a_done}, 32'd0);
        chk("idle_vld", {31'd0, a_vld}, 32'd0);
        chk("idle_cnt", {26'd0, a_cnt}, 32'd0);
        chk("loopback", loader, w);
    endtask

    initial begin
        rst = 1'b1;
        a_ld = 1'b0; a_rd = 1'b0; a_par = '0;
        b_ld = 1'b0; b_rd = 1'b0; b_par = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_rdy", {31'd0, a_rdy}, 32'd1);
        chk("rst_vld", {31'd0, a_vld}, 32'd0);
        chk("rst_ser", {31'd0, a_ser}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_cnt", {26'd0, a_cnt}, 32'd0);

        // rd high while idle must not start anything
        a_rd = 1'b1;
        step();
        chk("idle_rd_vld", {31'd0, a_vld}, 32'd0);

        // 1.0f: 23 zeros, seven ones, two zeros
        send(32'h3F80_0000, -1, 0, 1'b0, 32'h0);

        // Stall three cycles on bit 5
        send(32'hA5A5_A5A5, 5, 3, 1'b0, 32'h0);

        // ld held high: second word captured only on the idle cycle
        send(32'h1234_5678, -1, 0, 1'b1, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, -1, 0, 1'b0, 32'h0);

        // Reset mid-word at count 17
        a_par = 32'hA5A5_A5A5;
        a_ld  = 1'b1;
        a_rd  = 1'b1;
        step();
        a_ld = 1'b0;
        repeat (17) step();
        chk("pre_rst_cnt", {26'd0, a_cnt}, 32'd17);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_vld", {31'd0, a_vld}, 32'd0);
        chk("midrst_rdy", {31'd0, a_rdy}, 32'd1);
        chk("midrst_cnt", {26'd0, a_cnt}, 32'd0);
        chk("midrst_done", {31'd0, a_done}, 32'd0);
        step();
        chk("midrst_done2", {31'd0, a_done}, 32'd0);
        send(32'h0000_0001, -1, 0, 1'b0, 32'h0);

        // Reset and load on the same edge: load is dropped
        rst   = 1'b1;
        a_ld  = 1'b1;
        a_par = 32'hDEAD_BEEF;
        step();
        rst  = 1'b0;
        a_ld = 1'b0;
        chk("rstld_vld", {31'd0, a_vld}, 32'd0);
        step();
        chk("rstld_vld2", {31'd0, a_vld}, 32'd0);
        chk("rstld_rdy", {31'd0, a_rdy}, 32'd1);

        // MSB-first instance: 0x80000000 -> 1 then 31 zeros
        b_par = 32'h8000_0000;
        b_ld  = 1'b1;
        b_rd  = 1'b1;
        step();
        b_ld = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("msb_bit", {31'd0, b_ser}, (i == 0) ? 32'd1 : 32'd0);
            chk("msb_vld", {31'd0, b_vld}, 32'd1);
            step();
        end
        chk("msb_done", {31'd0, b_done}, 32'd1);
        chk("msb_cnt", {26'd0, b_cnt}, 32'd32);
        step();
        chk("msb_idle", {31'd0, b_rdy}, 32'd1);

        // Loopback of pi
        send(32'h4049_0FDB, -1, 0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_result_serializer.md
# fp_result_serializer

Parallel-to-serial output stage for the FP adder datapath: captures one 32-bit result word and shifts it out one bit per accepted transfer. Sits directly downstream of the adder core and mirrors the serial operand loaders upstream: LSB first by default, so a downstream serial-in loader reassembles the word unchanged. Flow control uses a ready/valid pair on each side, and a one-cycle done pulse marks the end of a word.

## Interface
- WIDTH, 32, word width in bits; must be ≥ 2
- LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit WIDTH-1 shifted first
- clk_in  input  1  single clock; all state updates on the rising edge
- rst_in  input  1  reset, synchronous, active-high
- ld_in  input  1  load request; sampled only while output_rdy=1
- parallel_in  input  WIDTH  result word, captured on an accepted load
- rd_in  input  1  downstream accepts the current bit this cycle
- serial_out  output  1  current bit; forced 0 whenever out_valid=0
- out_valid  output  1  serial_out holds a valid bit
- output_rdy  output  1  block idle, able to accept a load
- done_out  output  1  one-cycle pulse after the last bit is accepted
- bit_cnt_out  output  $clog2(WIDTH+1)  number of bits accepted in the current word

## Operation
- Synchronous reset: state=IDLE, shift register=0, count=0. Output values: output_rdy=1, out_valid=0, serial_out=0, done_out=0, bit_cnt_out=0. Reset overrides every other input on the same edge.
- FSM states: IDLE, SHIFT, DONE. The state and count are registered. All outputs are decoded from registered state only, with no combinational path from any input to any output.
- IDLE:
  - Outputs: output_rdy=1, out_valid=0.
  - If ld_in=1: capture parallel_in into the shift register, clear count, go to SHIFT.
  - If ld_in=0: stay in IDLE; the shift register holds its value.
- SHIFT:
  - Outputs: out_valid=1, output_rdy=0.
  - serial_out = sreg[0] when LSB_FIRST=1, otherwise sreg[WIDTH-1].
  - A transfer occurs on a cycle with out_valid=1 and rd_in=1. On that edge the register shifts by one toward the output end, filling with 0, and count increments.
  - When rd_in=0: the shift register, count and serial_out all hold. Stalls of any length are legal.
  - A transfer with count=WIDTH-1 moves the FSM to DONE, and count becomes WIDTH.
- DONE:
  - Lasts exactly one cycle.
  - Outputs: done_out=1, out_valid=0, output_rdy=0, bit_cnt_out=WIDTH.
  - Next state is IDLE; count clears on entry to IDLE.
- ld_in is ignored in SHIFT and DONE. A word is never overwritten or truncated by a new load.
- rd_in is ignored outside SHIFT.
- bit_cnt_out = count.

## Timing
- Load accepted at edge k:
  - first bit (bit 0 for LSB_FIRST=1) is valid on serial_out in cycle k+1;
  - with rd_in held at 1, bit i is presented in cycle k+1+i;
  - done_out=1 in cycle k+WIDTH+1;
  - output_rdy=1 again in cycle k+WIDTH+2.
- Minimum spacing between accepted loads with no stalls: WIDTH+2 cycles (34 cycles for WIDTH=32).
- Each cycle of rd_in=0 during SHIFT adds exactly one cycle to that schedule.
- rd_in=0 on the cycle carrying the final bit: stay in SHIFT with count=WIDTH-1 until rd_in=1.
- Reset asserted during SHIFT or DONE:
  - the current word is discarded and no done_out is produced;
  - the block is in IDLE on the cycle after the reset edge.
- Reset and ld_in high on the same edge: the load is not captured.

## Test plan
- Reset, then load 0x3F800000 with rd_in=1 (LSB_FIRST=1): 23 zeros, then seven 1s, then 0, 0 on serial_out across cycles 1..32 after the load; done_out pulses once in cycle 33; output_rdy=1 in cycle 34.
- Load 0xA5A5A5A5 and drop rd_in for 3 cycles after bit 5: the bit 5 value holds for 4 cycles, bit_cnt_out holds at 5, and done_out is delayed by exactly 3 cycles.
- ld_in held high continuously with 0x12345678 then 0xFFFFFFFF on parallel_in: the first word is sent intact; the second word is captured only on the IDLE cycle, 34 cycles after the first load.
- Assert rst_in while bit_cnt_out=17: next cycle out_valid=0, output_rdy=1, bit_cnt_out=0, with no done_out pulse; a following load of 0x00000001 sends 1 then 31 zeros.
- LSB_FIRST=0 with load 0x80000000: 1 then 31 zeros, followed by done_out.
- Loopback into the upstream serial-in loader for 0x40490FDB: the loader's parallel output equals 0x40490FDB after 32 transfers.
